ram_32x4_write_sequencer: RTL

//  Upstream loader for the 32x4 dual-port RAM show-time stage.

---
 rtl/ram_32x4_write_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ram_32x4_write_sequencer.sv
// ram_32x4_write_sequencer
//   Upstream loader for the 32x4 dual-port RAM show-time stage. Each debounced
//   press of the store key becomes one single-cycle RAM write of data_in at an
//   auto-incrementing address; fill status is reported on full/count.
//   Optional feature macro: RAM_WRITE_WRAP_EN. When it is defined, the address
//   wraps after the last location and writes continue, overwriting the oldest
//   entries. When it is undefined, the sequencer parks in FULL until reset.
module ram_32x4_write_sequencer #(
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  key,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  write,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int                  CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH + 1)'(1 << ADDR_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic                  r_key_meta;
  logic                  r_key_s;
  logic                  r_key_db;
  logic                  r_key_db_d;
  logic                  r_press_p;
  logic [CNT_W-1:0]      r_db_cnt;
  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_full;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  w_start;
  logic                  w_last;

  // Two-flop synchroniser bringing the asynchronous key into the clock domain.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_key_meta <= 1'b0;
      r_key_s    <= 1'b0;
    end else begin
      r_key_meta <= key;
      r_key_s    <= r_key_meta;
    end
  end

  // Debounce: key_db follows key_s only after key_s has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_key_db <= 1'b0;
    end else if (r_key_s == r_key_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_key_db <= r_key_s;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  // Registered one-cycle press pulse on the debounced rising edge only.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_key_db_d <= 1'b0;
      r_press_p  <= 1'b0;
    end else begin
      r_key_db_d <= r_key_db;
      r_press_p  <= r_key_db & ~r_key_db_d;
    end
  end

  assign w_start = (r_state == S_IDLE) && r_press_p && enable;
  assign w_last  = (r_addr == ADDR_LAST);

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic; presses outside IDLE are simply dropped.
  // NOTE: the default assignment first keeps every path assigned, so no latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_WRITE;
`ifdef RAM_WRITE_WRAP_EN
      S_WRITE: w_state_next = S_IDLE;
`else
      S_WRITE: w_state_next = w_last ? S_FULL : S_IDLE;
`endif
      S_FULL:  w_state_next = S_FULL;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Write datapath: capture data entering WRITE, advance address and count leaving it.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_addr  <= '0;
      r_full  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_start) r_data <= data_in;
      if (r_state == S_WRITE) begin
        if (r_count != COUNT_MAX) r_count <= r_count + (ADDR_WIDTH + 1)'(1);
        if (w_last) r_full <= 1'b1;
`ifdef RAM_WRITE_WRAP_EN
        r_addr <= r_addr + ADDR_WIDTH'(1);
`else
        if (!w_last) r_addr <= r_addr + ADDR_WIDTH'(1);
`endif
      end
    end
  end

  // The strobe is decoded from the state flops, so an async reset drops it at once.
  assign write      = (r_state == S_WRITE);
  assign write_addr = r_addr;
  assign data       = r_data;
  assign full       = r_full;
  assign count      = r_count;

endmodule
